// File: rtl/finalizer_snd_pkg.sv
// Shared widths, defaults and FSM state type for the finalizer sound path.
// Imported by the DC-blocking high-pass and its helpers.
package finalizer_snd_pkg;

  localparam int AUDIO_W     = 16;
  localparam int COEF_W      = 18;
  localparam int COEF_FRAC   = 17;
  localparam int ACC_W       = 40;
  localparam int PROD_W      = 2 * COEF_W;
  localparam int DIV_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE,
    MUL_X,
    MUL_Y,
    SUM
  } hpf_st_t;

endpackage

// File: rtl/finalizer_sat16.sv
// Round-half-up, arithmetic shift and saturate a Q.17 accumulator
// down to a signed 16-bit audio sample.
module finalizer_sat16
  import finalizer_snd_pkg::*;
(
  input  logic signed [ACC_W-1:0]   acc,
  output logic signed [AUDIO_W-1:0] y
);

  localparam int SH_W = ACC_W - COEF_FRAC;

  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(1) << (COEF_FRAC - 1);

  localparam logic signed [SH_W-1:0] MAXV =
    SH_W'(2 ** (AUDIO_W - 1) - 1);

  localparam logic signed [SH_W-1:0] MINV =
    SH_W'(-(2 ** (AUDIO_W - 1)));

  logic signed [ACC_W-1:0] rnd;
  logic signed [SH_W-1:0]  r;

  always_comb begin
    rnd = acc + HALF;
    r   = SH_W'(rnd >>> COEF_FRAC);
    if (r > MAXV) begin
      y = {1'b0, {(AUDIO_W-1){1'b1}}};
    end else if (r < MINV) begin
      y = {1'b1, {(AUDIO_W-1){1'b0}}};
    end else begin
      y = r[AUDIO_W-1:0];
    end
  end

endmodule

// File: rtl/finalizer_hpf.sv
// First-order DC-blocking high-pass on the mixed audio bus; one shared
// 18x18 multiplier sequenced by a four-state FSM per sample strobe.
module finalizer_hpf
  import finalizer_snd_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter logic signed [COEF_W-1:0] B1 = 18'sd131050,
  parameter logic signed [COEF_W-1:0] A1 = 18'sd131029
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bypass,
  input  logic signed [AUDIO_W-1:0] in,
  output logic signed [AUDIO_W-1:0] out,
  output logic                      out_valid
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 4) begin : g_div_chk
    $error("finalizer_hpf: DIV must be >= 4");
  end

  hpf_st_t                   st;
  logic [CNT_W-1:0]          cnt;
  logic                      strobe;
  logic                      byp;
  logic signed [AUDIO_W-1:0] x_cur;
  logic signed [AUDIO_W-1:0] x1;
  logic signed [AUDIO_W-1:0] y1;
  logic signed [ACC_W-1:0]   acc;

  logic signed [AUDIO_W:0]   d;
  logic signed [COEF_W-1:0]  ma;
  logic signed [COEF_W-1:0]  mb;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [AUDIO_W-1:0] r;

  assign strobe = (cnt == CNT_W'(DIV - 1));

  // Single multiplier: B1*d in MUL_X, A1*y1 otherwise.
  always_comb begin
    d = {x_cur[AUDIO_W-1], x_cur}
      - {x1[AUDIO_W-1], x1};
    ma = A1;
    mb = {y1[AUDIO_W-1], y1[AUDIO_W-1], y1};
    unique case (1'b1)
      (st == MUL_X): begin
        ma = B1;
        mb = {d[AUDIO_W], d};
      end
      default: ;
    endcase
    prod     = PROD_W'(ma) * PROD_W'(mb);
    prod_ext = ACC_W'(prod);
  end

  finalizer_sat16 u_sat (
    .acc (acc),
    .y   (r)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      st        <= IDLE;
      byp       <= 1'b0;
      x_cur     <= '0;
      x1        <= '0;
      y1        <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      cnt       <= strobe ? '0 : cnt + CNT_W'(1);
      unique case (st)
        IDLE: begin
          if (strobe) begin
            x_cur <= in;
            byp   <= bypass;
            st    <= MUL_X;
          end
        end
        MUL_X: begin
          acc <= prod_ext;
          st  <= MUL_Y;
        end
        MUL_Y: begin
          acc <= acc + prod_ext;
          st  <= SUM;
        end
        SUM: begin
          // Bypass reseeds state so leaving it has no step.
          if (byp) begin
            out <= x_cur;
            y1  <= '0;
          end else begin
            out <= r;
            y1  <= r;
          end
          x1        <= x_cur;
          out_valid <= 1'b1;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_finalizer_hpf.sv
// Directed bench for finalizer_hpf: hand-computed samples, latency,
// bypass, saturation, mid-pass reset and Nyquist input.
module tb_finalizer_hpf;
  import finalizer_snd_pkg::*;

  localparam int DIV = DIV_DEFAULT;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               bypass = 1'b0;
  logic signed [15:0] in = '0;
  logic signed [15:0] out;
  logic               out_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic signed [15:0] o;
  int                 at;

  finalizer_hpf #(.DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .bypass    (bypass),
    .in        (in),
    .out       (out),
    .out_valid (out_valid)
  );

  always #10 clk = ~clk;

  // Clocks since reset release; strobe edges are multiples of DIV.
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output logic signed [15:0] v,
                            output int t);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (out_valid !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_timeout", out_valid, 1);
    v = out;
    t = cyc;
  endtask

  task automatic sample(input int v, input logic b,
                        input string tag, input int exp);
    logic signed [15:0] got;
    int                 t;
    in = 16'(v);
    bypass = b;
    wait_valid(got, t);
    chk({tag, "_lat"}, t % DIV, 3);
    chk(tag, got, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, out_valid, 0);
    chk({tag, "_hold"}, out, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #5 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    reset = 1'b1;

    wait_valid(o, at);
    chk("first_lat", at, DIV + 3);
    chk("zero_first", o, 0);
    repeat (6) sample(0, 1'b0, "zero", 0);

    sample(10000, 1'b0, "dc1", 9998);
    sample(10000, 1'b0, "dc2", 9995);
    sample(10000, 1'b0, "dc3", 9992);

    do_reset();
    sample(1234, 1'b1, "byp", 1234);
    sample(1234, 1'b0, "byp_off", 0);

    do_reset();
    sample(-32768, 1'b1, "fs_pre", -32768);
    sample(32767, 1'b0, "fs_pos", 32767);
    sample(-32768, 1'b0, "fs_back", -32768);
    sample(32767, 1'b1, "fs_pre2", 32767);
    sample(-32768, 1'b0, "fs_neg", -32768);

    // Drop reset while the next pass sits in MUL_Y.
    in = 16'sd5000;
    bypass = 1'b0;
    for (int n = 0; n < 300 && (cyc % DIV) != 1; n++) begin
      @(posedge clk); #1;
    end
    chk("mid_phase", cyc % DIV, 1);
    reset = 1'b0;
    #1;
    chk("mid_out", out, 0);
    chk("mid_valid", out_valid, 0);
    repeat (4) @(negedge clk);
    chk("mid_hold_valid", out_valid, 0);
    reset = 1'b1;
    wait_valid(o, at);
    chk("mid_lat", at, DIV + 3);
    chk("mid_first", o, 4999);

    do_reset();
    sample(16000, 1'b0, "nyq0", 15997);
    sample(-16000, 1'b0, "nyq1", -16003);
    sample(16000, 1'b0, "nyq2", 15997);
    sample(-16000, 1'b0, "nyq3", -16003);
    sample(16000, 1'b0, "nyq4", 15997);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
